// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset PC, opcode length bit and fetch FSM encoding
package cpu_pkg;

  localparam int             CPU_AW       = 8;
  localparam int             CPU_DW       = 8;
  localparam logic [7:0]     CPU_RESET_PC = 8'h00;
  localparam int             OP_LEN_BIT   = 7;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_e;

  function automatic logic is_long(input logic [CPU_DW-1:0] op);
    return op[OP_LEN_BIT];
  endfunction

endpackage

// File: rtl/byte_skid.sv
// rtl/byte_skid.sv - two-entry skid FIFO for fetched bytes (tagged with their pc)
module byte_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         do_push;
  logic         do_pop;

  assign full    = (occ == 2'd2);
  assign empty   = (occ == 2'd0);
  assign head    = ent0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // ent0 is always the head; a pop shifts ent1 down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (clr) begin
      occ <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: issues InstMem reads, assembles 1/2-byte instructions
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int            AW       = CPU_AW,
  parameter int            DW       = CPU_DW,
  parameter logic [AW-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dout,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_op,
  output logic [DW-1:0] instr_imm,
  output logic [AW-1:0] instr_pc,
  output logic          instr_len
);

  localparam int            EW     = AW + DW;
  localparam logic [AW-1:0] PC_ONE = 1;

  logic [AW-1:0] fpc;
  logic [AW-1:0] rpc;
  logic          rv;
  logic [2:0]    pending;
  logic          issue;

  logic [1:0]    occ;
  logic          skid_full;
  logic          skid_empty;
  logic [EW-1:0] skid_head;
  logic          push;
  logic          pop;

  logic          avail;
  logic [DW-1:0] cur_byte;
  logic [AW-1:0] cur_pc;
  logic          slot_free;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic          consume;
  logic          latch_op;
  logic          load;
  logic [DW-1:0] ld_op;
  logic [DW-1:0] ld_imm;
  logic [AW-1:0] ld_pc;
  logic          ld_len;
  logic [DW-1:0] op_q;
  logic [AW-1:0] pc_q;

  assign mem_addr = fpc;

  // Counting the read in flight keeps the FIFO from ever needing a third slot
  assign pending = {1'b0, occ} + {2'b00, rv};
  assign issue   = (pending < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
      rpc <= RESET_PC;
      rv  <= 1'b0;
    end else if (redir_valid) begin
      fpc <= redir_pc;
      rv  <= 1'b0;
    end else if (issue) begin
      fpc <= fpc + PC_ONE;
      rpc <= fpc;
      rv  <= 1'b1;
    end else begin
      rv  <= 1'b0;
    end
  end

  assign avail    = !skid_empty || rv;
  assign cur_byte = skid_empty ? mem_dout : skid_head[DW-1:0];
  assign cur_pc   = skid_empty ? rpc      : skid_head[EW-1:DW];
  assign pop      = consume && !skid_empty;
  assign push     = rv && !(consume && skid_empty);

  byte_skid #(.W(EW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (redir_valid),
    .push  (push),
    .din   ({rpc, mem_dout}),
    .pop   (pop),
    .occ   (occ),
    .head  (skid_head),
    .full  (skid_full),
    .empty (skid_empty)
  );

  assign slot_free = !instr_valid || instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              state <= S_OP;
    else if (redir_valid) state <= S_OP;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_OP:    if (avail && is_long(cur_byte)) state_nxt = S_IMM;
      S_IMM:   if (avail && slot_free)         state_nxt = S_OP;
      default: state_nxt = S_OP;
    endcase
  end

  // A long opcode is taken without waiting for the output slot
  always_comb begin
    consume  = 1'b0;
    latch_op = 1'b0;
    load     = 1'b0;
    ld_op    = '0;
    ld_imm   = '0;
    ld_pc    = '0;
    ld_len   = 1'b0;
    case (state)
      S_OP: begin
        if (avail) begin
          if (is_long(cur_byte)) begin
            consume  = 1'b1;
            latch_op = 1'b1;
          end else if (slot_free) begin
            consume = 1'b1;
            load    = 1'b1;
            ld_op   = cur_byte;
            ld_pc   = cur_pc;
          end
        end
      end
      S_IMM: begin
        if (avail && slot_free) begin
          consume = 1'b1;
          load    = 1'b1;
          ld_op   = op_q;
          ld_imm  = cur_byte;
          ld_pc   = pc_q;
          ld_len  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      pc_q <= '0;
    end else if (latch_op && !redir_valid) begin
      op_q <= cur_byte;
      pc_q <= cur_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_op    <= '0;
      instr_imm   <= '0;
      instr_pc    <= '0;
      instr_len   <= 1'b0;
    end else if (redir_valid) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_valid <= 1'b1;
      instr_op    <= ld_op;
      instr_imm   <= ld_imm;
      instr_pc    <= ld_pc;
      instr_len   <= ld_len;
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 8-bit CPU. Drives the read address of `InstMem` port A and consumes its one-cycle-latency read data. Assembles 1- or 2-byte instructions and hands them to decode through a valid/ready handshake. Supports PC redirects from execute, which flush all in-flight fetch state.

## Interface
- `AW`, 8: PC and instruction-memory address width.
- `DW`, 8: instruction byte width.
- `RESET_PC`, 8'h00: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; also drives `InstMem` `clka`.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_addr`  out  AW  to `InstMem` `addra`; equals the fetch PC register.
- `mem_dout`  in  DW  from `InstMem` `douta`; holds mem[address sampled at the previous edge].
- `redir_valid`  in  1  redirect request (taken branch or jump).
- `redir_pc`  in  AW  redirect target.
- `instr_valid`  out  1  output instruction valid.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr_op`  out  DW  opcode byte.
- `instr_imm`  out  DW  operand byte; 0 when `instr_len`=0.
- `instr_pc`  out  AW  address of the opcode byte.
- `instr_len`  out  1  0 = 1-byte instruction, 1 = 2-byte instruction.

## Operation
- Length rule: `op[7]`=1 means a 2-byte instruction (opcode + imm); otherwise 1 byte.
- Issue:
  - `fpc` drives `mem_addr`.
  - An issue happens on an edge where `occ + inflight < 2`. `occ` is the skid FIFO count (0..2); `inflight` is 1 if a read was issued last edge.
  - On issue: `fpc <= fpc+1` (mod 256), `rv <= 1`, `rpc <= fpc`. Otherwise `rv <= 0` and `fpc` holds.
- Byte source:
  - Use the skid FIFO head if it is non-empty; else `mem_dout` when `rv`=1 (bypass).
  - An arriving byte not consumed this cycle is pushed into the FIFO.
  - This arrangement cannot overflow the FIFO.
- Assembler FSM:
  - `S_OP`: consume an opcode when a byte is available.
    - 1-byte opcode: emit only if the output slot is free.
    - 2-byte opcode: latch `op_q` and `pc_q`, then go to `S_IMM`.
  - `S_IMM`: consume the next byte as imm when the output slot is free. Emit with len=1, then go to `S_OP`.
- Output slot:
  - Free when `!instr_valid || instr_ready`.
  - Loading sets `instr_valid`=1.
  - A handshake with nothing new to load clears `instr_valid`.
- Redirect (highest priority):
  - `fpc <= redir_pc`, `rv <= 0`, FIFO cleared, FSM to `S_OP`, `instr_valid <= 0`.
  - A same-cycle `instr_valid && instr_ready` handshake counts as completed.
  - No byte consumed in the redirect cycle is used.
- Wrap: `fpc` 8'hFF+1 = 8'h00. A 2-byte instruction at 8'hFF takes its imm from 8'h00.
- Reset values:
  - `fpc`=RESET_PC, `mem_addr`=RESET_PC.
  - `rv`=0, `occ`=0, FSM=`S_OP`.
  - `instr_valid`=0; `instr_op`, `instr_imm`, `instr_pc`, `instr_len` = 0.

## Timing
- Memory read latency is 1 cycle: the address is sampled at edge E and data is valid during the cycle after E.
- Reset release or redirect at edge N:
  - Target address sampled at edge N+1.
  - A 1-byte instruction is valid after edge N+2.
  - A 2-byte instruction is valid after edge N+3.
- Peak throughput with `instr_ready` tied high:
  - 1-byte instructions: one per cycle.
  - 2-byte instructions: one per 2 cycles.
- Backpressure:
  - Output registers hold stable while `instr_valid && !instr_ready`.
  - Issue stops within 1 cycle; at most 2 bytes are buffered.
  - No byte is lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The first fetch restarts at RESET_PC.

## Structure
- Shared package `cpu_pkg`:
  - `AW`/`DW` defaults and `RESET_PC`.
  - Length-bit position constant `OP_LEN_BIT`=7.
  - FSM state encoding `S_OP`/`S_IMM`.
- Sub-module `byte_skid`: 2-entry byte FIFO with push, pop, clear, `occ` and head outputs. Flags: full at 2, empty at 0, simultaneous push+pop keeps the count.
- The top level contains the issue logic, FSM and output register. Target size is about 200 lines.

## Test plan
- Reset release, memory = {8'h01, 8'h02, 8'h03}, `instr_ready`=1: `instr_valid` rises after edge 2. Three consecutive instructions, op=01/02/03, pc=0/1/2, len=0, one per cycle.
- Memory = {8'h85, 8'hAA, 8'h10}: instruction {op=85, imm=AA, pc=0, len=1} followed by {op=10, pc=2, len=0}.
- Hold `instr_ready`=0 for 5 cycles mid-stream, then release: outputs stable during the hold, `mem_addr` stops advancing, and the stream resumes in order with no gaps or duplicates.
- `redir_valid` with `redir_pc`=8'h40 while a read and a buffered byte are pending: nothing from the old path is emitted, and the instruction at pc=40 is valid after 2 edges.
- Memory[8'hFF]=8'h90, memory[8'h00]=8'h55, fetch from 8'hFF: {op=90, imm=55, pc=FF, len=1} is emitted, then fetch continues at 8'h01.
- Assert `rst` between clock edges while `S_IMM` is pending: `instr_valid` drops immediately, and after release fetch restarts at RESET_PC with no stale opcode.
